// File: rtl/transactor_slave.sv
// Completer for the sel/en transactor bus: word-addressed 32-bit register bank with
// programmable wait states. Define TRANSACTOR_SLAVE_SLVERR_EN to report misses on slverr.
module transactor_slave #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [16:0] BASE_ADDR   = 17'h00000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        en,
   input  logic [16:0] addr,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic        slverr
);

   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

`ifdef TRANSACTOR_SLAVE_SLVERR_EN
   localparam logic SLVERR_EN = 1'b1;
`else
   localparam logic SLVERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             slverr_q, slverr_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hit_q, hit_d;
   logic             wr_q, wr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             mem_we_s;
   logic [31:0]      mem_q [DEPTH];

   // Borrow bit of the 18-bit difference flags addresses below the window.
   function automatic logic addr_hit(input logic [16:0] a);
      logic [17:0] diff;
      diff = {1'b0, a} - {1'b0, BASE_ADDR};
      return !diff[17] && (diff[16:2] < 15'(DEPTH)) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [16:0] a);
      logic [16:0] diff;
      diff = a - BASE_ADDR;
      return diff[IDX_W+1:2];
   endfunction

   function automatic logic [31:0] read_word(input logic hit, input logic [IDX_W-1:0] idx);
      return hit ? mem_q[idx] : 32'h0000_0000;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      slverr_d  = 1'b0;
      rd_data_d = rd_data_q;
      idx_d     = idx_q;
      hit_d     = hit_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      mem_we_s  = 1'b0;
      if (sel && !en) begin
         // Latch the request; with no wait states the response is due in the next cycle.
         state_d = ST_SETUP;
         idx_d   = addr_idx(addr);
         hit_d   = addr_hit(addr);
         wr_d    = wr_en;
         wdata_d = wr_data;
         cnt_d   = WAIT_LD;
         if (WAIT_LD == 4'd0) begin
            ready_d  = 1'b1;
            slverr_d = SLVERR_EN && !hit_d;
            if (!wr_en) begin
               rd_data_d = read_word(hit_d, idx_d);
            end else begin
               rd_data_d = rd_data_q;
            end
         end else begin
            ready_d = 1'b0;
         end
      end else if (sel && en && (state_q != ST_IDLE)) begin
         if (ready_q) begin
            mem_we_s = wr_q && hit_q;
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
         end else begin
            state_d = ST_ACCESS;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               ready_d  = 1'b1;
               slverr_d = SLVERR_EN && !hit_q;
               if (!wr_q) begin
                  rd_data_d = read_word(hit_q, idx_q);
               end else begin
                  rd_data_d = rd_data_q;
               end
            end else begin
               ready_d = 1'b0;
            end
         end
      end else begin
         // Idle, abort (sel dropped) or an ignored sel&en without a preceding SETUP.
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end
   end

   // Control, request and output registers.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         ready_q   <= 1'b0;
         slverr_q  <= 1'b0;
         rd_data_q <= 32'h0000_0000;
         idx_q     <= '0;
         hit_q     <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         slverr_q  <= slverr_d;
         rd_data_q <= rd_data_d;
         idx_q     <= idx_d;
         hit_q     <= hit_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Register bank; a write lands on the edge closing its completing cycle.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (mem_we_s) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rd_data = rd_data_q;
   assign ready   = ready_q;
   assign slverr  = slverr_q;

endmodule

// File: tb/tb_transactor_slave.sv
// Randomized bench for transactor_slave: a zero-wait and a three-wait instance, each
// compared every cycle against a transfer-level model, plus literal directed checks.
module tb_transactor_slave;

   localparam int NW = 64;

`ifdef TRANSACTOR_SLAVE_SLVERR_EN
   localparam bit SLV = 1'b1;
`else
   localparam bit SLV = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel_s, en_s, wr_s, rdy_s, err_s;
   logic [16:0] addr_s [2];
   logic [31:0] wdat_s [2];
   logic [31:0] rd_s   [2];

   always #5 clk = ~clk;

   transactor_slave #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(17'h00000)) dut0 (
      .sys_clk(clk), .rst(rst), .sel(sel_s[0]), .en(en_s[0]), .addr(addr_s[0]),
      .wr_en(wr_s[0]), .wr_data(wdat_s[0]), .rd_data(rd_s[0]), .ready(rdy_s[0]),
      .slverr(err_s[0]));

   transactor_slave #(.DEPTH(64), .WAIT_CYCLES(3), .BASE_ADDR(17'h00000)) dut3 (
      .sys_clk(clk), .rst(rst), .sel(sel_s[1]), .en(en_s[1]), .addr(addr_s[1]),
      .wr_en(wr_s[1]), .wr_data(wdat_s[1]), .rd_data(rd_s[1]), .ready(rdy_s[1]),
      .slverr(err_s[1]));

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   logic [31:0] mem_m [2][NW];
   logic        exp_rdy [2];
   logic        exp_err [2];
   logic [31:0] exp_rd  [2];
   int          setup_cyc [2];
   int          rdy_cyc [2];
   int          prev_rdy_cyc [2];
   int          rdy_cnt [2];
   logic        last_err [2];

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[inst%0d]: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
      end
   endtask

   function automatic bit is_hit(input logic [16:0] a);
      return (a[1:0] == 2'b00) && ((int'(a) >> 2) < NW);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Cycle-by-cycle comparison of both instances against the model expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check("ready", k, 32'(rdy_s[k]), 32'(exp_rdy[k]));
            check("slverr", k, 32'(err_s[k]), 32'(exp_err[k]));
            check("rd_data", k, rd_s[k], exp_rd[k]);
            if (rdy_s[k] === 1'b1) begin
               prev_rdy_cyc[k] <= rdy_cyc[k];
               rdy_cyc[k]      <= cyc;
               rdy_cnt[k]      <= rdy_cnt[k] + 1;
               last_err[k]     <= err_s[k];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_rdy[k] = 1'b0;
         exp_err[k] = 1'b0;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      step();
      sel_s[k] = 1'b0;
      en_s[k]  = 1'b0;
   endtask

   // One master transfer; abort_at >= 0 drops sel in that ACCESS cycle.
   task automatic xfer(input int k, input logic [16:0] a, input logic w, input logic [31:0] d,
                       input int abort_at);
      int wt;
      wt = (k == 0) ? 0 : 3;
      step();
      sel_s[k] = 1'b1; en_s[k] = 1'b0; addr_s[k] = a; wr_s[k] = w; wdat_s[k] = d;
      setup_cyc[k] = cyc;
      for (int i = 0; i <= wt; i++) begin
         step();
         addr_s[k] = 17'($urandom);
         wdat_s[k] = $urandom;
         wr_s[k]   = 1'($urandom);
         if (i == abort_at) begin
            sel_s[k] = 1'b0;
            en_s[k]  = 1'b0;
            return;
         end
         en_s[k] = 1'b1;
         if (i == wt) begin
            exp_rdy[k] = 1'b1;
            exp_err[k] = SLV && !is_hit(a);
            if (!w) exp_rd[k] = is_hit(a) ? mem_m[k][a[7:2]] : 32'h0000_0000;
         end
      end
      if (w && is_hit(a)) mem_m[k][a[7:2]] = d;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         exp_rd[k] = 32'h0000_0000;
         for (int j = 0; j < NW; j++) mem_m[k][j] = 32'h0000_0000;
      end
   endtask

   initial begin
      int cnt_before;
      logic [16:0] ra;
      int ab;
      rst = 1'b1;
      sel_s = 2'b00; en_s = 2'b00; wr_s = 2'b00;
      for (int k = 0; k < 2; k++) begin
         addr_s[k] = 17'h0; wdat_s[k] = 32'h0; exp_rdy[k] = 1'b0; exp_err[k] = 1'b0;
         setup_cyc[k] = 0; rdy_cyc[k] = 0; prev_rdy_cyc[k] = 0; rdy_cnt[k] = 0; last_err[k] = 1'b0;
      end
      clear_model();
      step(); step();
      chk_en = 1'b1;
      settle();
      check("rst_rd", 0, rd_s[0], 32'h0);
      check("rst_rd", 1, rd_s[1], 32'h0);
      step();
      rst = 1'b0;

      // Zero-wait write/read, back-to-back RAW, misses.
      xfer(0, 17'h0010, 1'b1, 32'hDEAD_BEEF, -1);
      settle();
      check("wr_latency", 0, 32'(rdy_cyc[0] - setup_cyc[0]), 32'd1);
      idle(0);
      xfer(0, 17'h0010, 1'b0, 32'h0, -1);
      settle();
      check("rd_latency", 0, 32'(rdy_cyc[0] - setup_cyc[0]), 32'd1);
      check("rd_value", 0, rd_s[0], 32'hDEAD_BEEF);
      check("rd_slverr", 0, 32'(last_err[0]), 32'd0);
      idle(0);
      xfer(0, 17'h0008, 1'b1, 32'h1234_5678, -1);
      xfer(0, 17'h0008, 1'b0, 32'h0, -1);
      settle();
      check("b2b_value", 0, rd_s[0], 32'h1234_5678);
      check("b2b_period", 0, 32'(rdy_cyc[0] - prev_rdy_cyc[0]), 32'd2);
      idle(0);
      xfer(0, 17'h0000, 1'b1, 32'hA5A5_0000, -1);
      xfer(0, 17'h0100, 1'b0, 32'h0, -1);
      settle();
      check("miss_rd", 0, rd_s[0], 32'h0);
      check("miss_err", 0, 32'(last_err[0]), 32'(SLV));
      xfer(0, 17'h0002, 1'b1, 32'hFFFF_FFFF, -1);
      settle();
      check("misalign_err", 0, 32'(last_err[0]), 32'(SLV));
      xfer(0, 17'h0000, 1'b0, 32'h0, -1);
      settle();
      check("word0_kept", 0, rd_s[0], 32'hA5A5_0000);
      idle(0);

      // Three wait states, abort, reset mid-write.
      xfer(1, 17'h0004, 1'b1, 32'h0BAD_F00D, -1);
      idle(1);
      xfer(1, 17'h0004, 1'b0, 32'h0, -1);
      settle();
      check("wait_latency", 1, 32'(rdy_cyc[1] - setup_cyc[1]), 32'd4);
      check("wait_rd", 1, rd_s[1], 32'h0BAD_F00D);
      xfer(1, 17'h000C, 1'b1, 32'h3333_3333, -1);
      idle(1);
      cnt_before = rdy_cnt[1];
      xfer(1, 17'h000C, 1'b1, 32'hFFFF_FFFF, 1);
      idle(1);
      settle();
      check("abort_noready", 1, 32'(rdy_cnt[1] - cnt_before), 32'd0);
      xfer(1, 17'h000C, 1'b0, 32'h0, -1);
      settle();
      check("abort_nowrite", 1, rd_s[1], 32'h3333_3333);
      idle(1);
      xfer(1, 17'h0010, 1'b1, 32'hCAFE_F00D, -1);
      idle(1);
      step();
      sel_s[1] = 1'b1; en_s[1] = 1'b0; addr_s[1] = 17'h0010; wr_s[1] = 1'b1; wdat_s[1] = 32'h1111_1111;
      step();
      en_s[1] = 1'b1;
      step();
      rst = 1'b1;
      step();
      clear_model();
      step();
      rst = 1'b0;
      sel_s = 2'b00; en_s = 2'b00;
      xfer(1, 17'h0010, 1'b0, 32'h0, -1);
      settle();
      check("rst_nowrite", 1, rd_s[1], 32'h0);
      idle(1);

      // Randomized traffic on both instances.
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) ra = 17'($urandom);
            else ra = 17'({$urandom_range(0, 79), 2'b00});
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            ab = (k == 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            xfer(k, ra, 1'($urandom), $urandom, ab);
            if (ab >= 0 || $urandom_range(0, 1) == 0) idle(k);
         end
         idle(k);
      end
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/transactor_slave.md
# transactor_slave

Responder (completer) end of the transactor bus driven by the master transactor model. It decodes SETUP/ACCESS phases on `sel`/`en`, services 32-bit reads and writes into an internal word-addressed register bank, and inserts a configurable number of wait states before signalling completion on `ready`. It sits behind the bus interface as the DUT-side target for master-driven sequences, and also serves as a reference slave in bench loopback.

## Interface
- `DEPTH`, 64: number of 32-bit words in the register bank; power of two, range 4..1024.
- `WAIT_CYCLES`, 0: wait states inserted per transfer; range 0..15.
- `BASE_ADDR`, 17'h00000: byte address of word 0; word-aligned.

- `sys_clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `sel`  in  1  slave select; high for the whole transfer.
- `en`  in  1  enable; low in SETUP, high in ACCESS.
- `addr`  in  17  byte address; sampled in SETUP.
- `wr_en`  in  1  1 = write, 0 = read; sampled in SETUP.
- `wr_data`  in  32  write data; sampled in SETUP.
- `rd_data`  out  32  read data; valid while `ready` = 1 on a read.
- `ready`  out  1  transfer completes in the cycle where `sel & en & ready`.
- `slverr`  out  1  error flag; qualified by `ready`.

## Operation
- FSM states:
  - IDLE: `sel` = 0.
  - SETUP: `sel & !en` sampled.
  - ACCESS: `sel & en`, counting wait states.
- Transitions:
  - IDLE→SETUP when `sel & !en`. If `sel & en` is seen in IDLE, it is a protocol violation: ignored, stay in IDLE.
  - SETUP→ACCESS when `sel & en`.
  - SETUP→SETUP when `sel & !en` (re-sample `addr`, `wr_en`, `wr_data`).
  - SETUP→IDLE when `!sel`.
  - ACCESS→IDLE after the completing cycle if `!sel`; ACCESS→SETUP if `sel & !en` (back-to-back).
  - ACCESS→IDLE immediately if `sel` drops before completion (abort).
- Address decode (on the SETUP-sampled address): `idx = (addr - BASE_ADDR) >> 2`.
  - Hit: `addr >= BASE_ADDR`, `idx < DEPTH`, and `addr[1:0] == 0`.
  - Otherwise the access is a miss.
- Write hit: `mem[idx] <= wr_data` on the edge ending the completing cycle.
- Read hit: `rd_data` = `mem[idx]`, captured at end of SETUP.
- Miss: no write. `rd_data` = 32'h0. `slverr` behaviour per Configuration.
- An aborted transfer never commits a write. `rd_data` keeps its previous value.
- Read-after-write to the same word in a back-to-back transfer returns the new data; the write commits before the next SETUP capture.

## Timing
- All outputs are registered.
- Reset values:
  - `rd_data` = 0, `ready` = 0, `slverr` = 0.
  - All `mem` words = 0; FSM = IDLE; wait counter = 0.
- Reset during a transfer: abort, no write commits, outputs return to reset values on the next cycle.
- Wait counter: loaded with `WAIT_CYCLES` at the edge ending SETUP, then decrements each ACCESS cycle. `ready` rises on the edge at which the counter reaches 0.
- `WAIT_CYCLES = 0`: `ready` = 1 in the first ACCESS cycle (SETUP at T, complete at T+1).
- `WAIT_CYCLES = N`: `ready` = 1 in ACCESS cycle N+1; the transfer completes at T+1+N.
- `ready` is high for exactly one cycle per transfer, then 0 from the next cycle.
- `rd_data` holds its value until the next read completion.
- Minimum back-to-back period is 2 cycles per transfer at `WAIT_CYCLES = 0`.

## Configuration
- Macro: `TRANSACTOR_SLAVE_SLVERR_EN`.
- Defined: on a miss (out-of-range or misaligned), `slverr` = 1 together with `ready` in the completing cycle; otherwise 0.
- Undefined: `slverr` is tied to 0. Misses complete normally and silently: writes are dropped and reads return 0.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-write.
  - Outputs are 0, FSM is IDLE, the write is not committed.
  - A subsequent read of that word returns 32'h0.
- **Zero-wait write/read (`WAIT_CYCLES = 0`):**
  - Write 32'hDEAD_BEEF to addr 17'h0010; `ready` is high at T+1.
  - Read of 17'h0010 returns 32'hDEAD_BEEF with `ready` at T+1, `slverr` = 0.
- **Wait states (`WAIT_CYCLES = 3`):** read addr 17'h0004.
  - `ready` is low for 3 ACCESS cycles and high in the 4th.
  - Master holds `sel`/`en` throughout; the transfer completes at T+4.
- **Back-to-back:** write 32'h1234_5678 to 17'h0008, then directly (ACCESS→SETUP) read 17'h0008.
  - The read returns 32'h1234_5678.
  - Two transfers complete in 4 cycles.
- **Miss with `TRANSACTOR_SLAVE_SLVERR_EN`:**
  - Read 17'h0100 (`idx` = 64, DEPTH = 64): `rd_data` = 0, `slverr` = 1, `ready` = 1.
  - Write to misaligned 17'h0002: `slverr` = 1, and word 0 is unchanged.
  - Without the macro: the same stimulus gives `slverr` = 0.
- **Abort:** drop `sel` during wait cycle 2 of a write to 17'h000C (`WAIT_CYCLES = 3`).
  - `ready` never asserts, FSM returns to IDLE, word 3 is unchanged.
